// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port (WE3/A3/WD3) between the
// core's single-cycle writeback (wb0) and a long-latency unit (wb1).
// wb1 results are queued in a small FIFO. wb0 always has priority for the port.
// A scoreboard tracks registers with outstanding long-latency results.
// stall is raised for RAW/WAW hazards against those registers. It is also
// raised when the queued wb1 results have lost the port for too long.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   issue_valid/long/rd/rs1/rs2  instruction presented by the core
//   stall                        core must hold the current instruction
//   wb0_valid/rd/data            single-cycle writeback (gated by core with !stall)
//   wb1_valid/ready/rd/data      long-latency result handshake into the FIFO
//   WE3/A3/WD3                   register file write port
//   busy                         scoreboard, bit i = register i has a pending write
//   sb_err                       sticky protocol-violation flag
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    output logic                  stall,
    input  logic                  wb0_valid,
    input  logic [4:0]            wb0_rd,
    input  logic [DATA_WIDTH-1:0] wb0_data,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [4:0]            wb1_rd,
    input  logic [DATA_WIDTH-1:0] wb1_data,
    output logic                  WE3,
    output logic [4:0]            A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic [31:0]           busy,
    output logic                  sb_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // wb1 result FIFO. The head must be visible in the same cycle it is
    // written to the register file, so storage is a small register array
    // with an asynchronous head read.
    // ------------------------------------------------------------------
    logic [4:0]            fifo_rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [4:0]            head_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;

    assign fifo_empty = (count_reg == '0);
    // Full is judged on the pre-pop count, so a full FIFO never accepts a
    // push even in a cycle where it also pops.
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign head_rd    = fifo_rd_mem[rd_ptr_reg];
    assign head_data  = fifo_data_mem[rd_ptr_reg];

    assign wb1_ready  = !fifo_full && !rst;
    assign push       = wb1_valid && wb1_ready;
    // The head drains only when wb0 leaves the port free. An rd==0 head is
    // still consumed, even though the write enable stays low.
    assign pop        = !rst && !wb0_valid && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= wb1_rd;
            fifo_data_mem[wr_ptr_reg] <= wb1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port mux
    // ------------------------------------------------------------------
    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (wb0_valid) begin
            A3  = wb0_rd;
            WD3 = wb0_data;
            WE3 = !rst && (wb0_rd != 5'd0);
        end else if (!fifo_empty) begin
            A3  = head_rd;
            WD3 = head_data;
            WE3 = !rst && (head_rd != 5'd0);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [31:0] busy_reg;
    logic [31:0] busy_next;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        hazard_stall;
    logic        starve_stall_reg;
    logic        issue_set;

    assign stall     = hazard_stall || starve_stall_reg;
    assign issue_set = issue_valid && !stall && issue_long && (issue_rd != 5'd0);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb_mask
            assign set_mask[gi] = issue_set && (issue_rd == 5'(gi));
            assign clr_mask[gi] = pop && (head_rd == 5'(gi));
        end
    endgenerate

    always_comb begin
        busy_next    = (busy_reg & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

    always_comb begin
        hazard_stall = issue_valid &&
                       (((issue_rs1 != 5'd0) && busy_reg[issue_rs1]) ||
                        ((issue_rs2 != 5'd0) && busy_reg[issue_rs2]) ||
                        ((issue_rd  != 5'd0) && busy_reg[issue_rd]));
    end

    // ------------------------------------------------------------------
    // Starvation: count cycles a waiting FIFO head loses to wb0. Once the
    // limit is reached, stall the core so it stops issuing wb0 writes. The
    // head then drains on the following cycle.
    // ------------------------------------------------------------------
    logic [STV_W-1:0] starve_cnt_reg;
    logic [STV_W-1:0] starve_cnt_next;
    logic             starve_stall_next;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (fifo_empty || pop) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
        starve_stall_next = pop ? 1'b0
                                : (starve_stall_reg || (starve_cnt_next == STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg   <= '0;
            starve_stall_reg <= 1'b0;
        end else begin
            starve_cnt_reg   <= starve_cnt_next;
            starve_stall_reg <= starve_stall_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky protocol-violation flag
    // ------------------------------------------------------------------
    logic sb_err_reg;
    logic sb_err_next;

    always_comb begin
        sb_err_next = sb_err_reg;
        if (wb0_valid && busy_reg[wb0_rd]) begin
            sb_err_next = 1'b1;
        end
        if (pop && (head_rd != 5'd0) && !busy_reg[head_rd]) begin
            sb_err_next = 1'b1;
        end
        if (wb0_valid && starve_stall_reg) begin
            sb_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_reg <= 1'b0;
        end else begin
            sb_err_reg <= sb_err_next;
        end
    end

    assign sb_err = sb_err_reg;

endmodule
